spi_burst_sequencer: RTL and testbench

Command-side sequencer that sits directly upstream of the SPI master. It buffers outbound bytes in a small FIFO and issues one-cycle start pulses to the master, one byte at a time. It waits for the master's completion pulse before each next byte and returns every received byte with a valid strobe. This lets software or the switch/button logic queue multi-byte bursts without tracking master busy state.

---
 rtl/spi_burst_sequencer_if.sv | 31 +++
 rtl/spi_burst_sequencer.sv | 157 +++++++++++++++
 tb/tb_spi_burst_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_burst_sequencer_if.sv
// Bundled command/master/receive signals of spi_burst_sequencer.
// slave: the sequencer side; master: the producer + SPI master side.
interface spi_burst_sequencer_if #(
    parameter int unsigned DEPTH = 8
) ();
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic             wr_valid;
    logic [7:0]       wr_data;
    logic             wr_ready;
    logic             flush;
    logic             m_start;
    logic [7:0]       m_tx_data;
    logic             m_done;
    logic [7:0]       m_rx_data;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             busy;
    logic [LVL_W-1:0] level;
    logic             timeout_err;

    modport slave (
        input  wr_valid, wr_data, flush, m_done, m_rx_data,
        output wr_ready, m_start, m_tx_data, rx_data, rx_valid, busy, level, timeout_err
    );

    modport master (
        output wr_valid, wr_data, flush, m_done, m_rx_data,
        input  wr_ready, m_start, m_tx_data, rx_data, rx_valid, busy, level, timeout_err
    );
endinterface

// File: rtl/spi_burst_sequencer.sv
// Byte-burst sequencer in front of an SPI master: FIFO, one-shot launch, done wait, inter-byte gap.
// Optional WAIT_DONE watchdog enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_burst_sequencer #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_burst_sequencer_if.slave  bus_io
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               wr_ready_q, wr_ready_d;
    logic [7:0]         tx_q, tx_d, rx_q, rx_d;
    logic               rx_valid_q, rx_valid_d;
    logic               m_start_q, m_start_d;
    logic               busy_q, busy_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               terr_q, terr_d;
    logic [7:0]         mem_q [DEPTH];
    logic               push_c, pop_c, timeout_c;

    assign push_c = bus_io.wr_valid && wr_ready_q && !bus_io.flush;

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;

    // Counts clocks since launch; LAUNCH itself is clock 1.
    always_comb begin
        wd_d = wd_q;
        if (state_q == LAUNCH) begin
            wd_d = WD_W'(1);
        end else if (state_q == WAIT_DONE) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    assign timeout_c = (state_q == WAIT_DONE) && !bus_io.m_done
                       && (wd_q >= WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wd_q <= '0;
        else     wd_q <= wd_d;
    end
`else
    // Watchdog compiled out; the parameter only keeps the port list uniform.
    assign timeout_c = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    // Sequencer FSM and registered output next-values.
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rx_valid_d = 1'b0;
        terr_d     = terr_q;
        pop_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (level_q != '0 && !bus_io.flush) begin
                    pop_c   = 1'b1;
                    tx_d    = mem_q[rd_ptr_q];
                    state_d = LAUNCH;
                end
            end
            LAUNCH: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (bus_io.m_done) begin
                    rx_d       = bus_io.m_rx_data;
                    rx_valid_d = 1'b1;
                    gap_d      = GAP_W'(GAP_CYCLES);
                    state_d    = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else if (timeout_c) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_q == '0) state_d = IDLE;
                else             gap_d   = gap_q - GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase
        m_start_d = (state_d == LAUNCH);
        busy_d    = (state_d != IDLE);
    end

    // FIFO pointers and occupancy; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (bus_io.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            level_d = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
        end
        wr_ready_d = (level_d != LVL_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= bus_io.wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            wr_ready_q <= 1'b1;
            tx_q       <= 8'h00;
            rx_q       <= 8'h00;
            rx_valid_q <= 1'b0;
            m_start_q  <= 1'b0;
            busy_q     <= 1'b0;
            gap_q      <= '0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            wr_ready_q <= wr_ready_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rx_valid_q <= rx_valid_d;
            m_start_q  <= m_start_d;
            busy_q     <= busy_d;
            gap_q      <= gap_d;
            terr_q     <= terr_d;
        end
    end

    assign bus_io.wr_ready    = wr_ready_q;
    assign bus_io.m_start     = m_start_q;
    assign bus_io.m_tx_data   = tx_q;
    assign bus_io.rx_data     = rx_q;
    assign bus_io.rx_valid    = rx_valid_q;
    assign bus_io.busy        = busy_q;
    assign bus_io.level       = level_q;
    assign bus_io.timeout_err = terr_q;
endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Bench for spi_burst_sequencer: timestamp-based queue model checked every cycle,
// directed bursts, and literal expectations pinning latency and data.
module tb_spi_burst_sequencer;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned GAP      = 16;
    localparam int unsigned TMO      = 64;
    localparam int          RESP_DLY = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    spi_burst_sequencer_if #(.DEPTH(DEPTH)) bus ();

    spi_burst_sequencer #(
        .DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .bus_io(bus)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, exp);
        end
    endtask

    // SPI master stand-in: answers tx ^ 8'h99 RESP_DLY cycles after each start.
    int         pend_cyc  = -1;
    int         spur_cyc  = -1;
    logic [7:0] pend_data = 8'h00;
    bit         resp_en   = 1'b1;

    always @(negedge clk) begin
        if (bus.m_start && resp_en && !rst) begin
            pend_cyc  = cyc + RESP_DLY;
            pend_data = bus.m_tx_data ^ 8'h99;
        end
    end

    initial begin
        bus.m_done    = 1'b0;
        bus.m_rx_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            bus.m_done    = (cyc == pend_cyc) || (cyc == spur_cyc);
            bus.m_rx_data = (cyc == spur_cyc) ? 8'hEE : pend_data;
        end
    end

    // Model: FIFO contents as a queue, transfer phases as cycle timestamps.
    logic [7:0] q[$];
    bit         in_fl;
    int         launch_cyc, idle_from;
    int         e_level;
    bit         e_wr_ready, e_start, e_rxv, e_busy, e_terr;
    logic [7:0] e_tx, e_rx;
    bit         m_idle, m_push, m_pop, m_done, m_tmo;
    int         start_cyc[$];
    logic [7:0] start_dat[$];
    int         rxv_cyc[$];

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            in_fl = 0; idle_from = 0; launch_cyc = 0;
            e_level = 0; e_wr_ready = 1; e_start = 0; e_rxv = 0; e_busy = 0; e_terr = 0;
            e_tx = 8'h00; e_rx = 8'h00;
        end
        chk("level",       32'(bus.level),       32'(e_level));
        chk("wr_ready",    32'(bus.wr_ready),    32'(e_wr_ready));
        chk("m_start",     32'(bus.m_start),     32'(e_start));
        chk("m_tx_data",   32'(bus.m_tx_data),   32'(e_tx));
        chk("rx_valid",    32'(bus.rx_valid),    32'(e_rxv));
        chk("rx_data",     32'(bus.rx_data),     32'(e_rx));
        chk("busy",        32'(bus.busy),        32'(e_busy));
        chk("timeout_err", 32'(bus.timeout_err), 32'(e_terr));
        if (bus.m_start) begin
            start_cyc.push_back(cyc);
            start_dat.push_back(bus.m_tx_data);
        end
        if (bus.rx_valid) rxv_cyc.push_back(cyc);
        if (!rst) begin
            m_idle = !in_fl && (cyc >= idle_from);
            m_push = bus.wr_valid && e_wr_ready && !bus.flush;
            m_pop  = m_idle && (q.size() > 0) && !bus.flush;
            m_done = in_fl && (cyc > launch_cyc) && bus.m_done;
            m_tmo  = 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
            m_tmo  = in_fl && (cyc > launch_cyc) && !bus.m_done && (cyc == launch_cyc + int'(TMO) - 1);
`endif
            e_start = m_pop;
            e_rxv   = m_done;
            if (bus.flush) q.delete();
            else begin
                if (m_pop)  e_tx = q.pop_front();
                if (m_push) q.push_back(bus.wr_data);
            end
            if (m_pop) begin in_fl = 1; launch_cyc = cyc + 1; end
            if (m_done) begin
                e_rx      = bus.m_rx_data;
                in_fl     = 0;
                idle_from = cyc + 1 + ((GAP > 0) ? int'(GAP) + 1 : 0);
            end
            if (m_tmo) begin in_fl = 0; idle_from = cyc + 1; e_terr = 1; end
            e_busy     = in_fl || (cyc + 1 < idle_from);
            e_level    = q.size();
            e_wr_ready = (q.size() != DEPTH);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        bus.wr_valid = 1'b1;
        bus.wr_data  = b;
        step(1);
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_start(output int sc);
        int k = 0;
        while (!bus.m_start && k < 300) begin step(1); k++; end
        if (!bus.m_start) chk("wait_start_bound", 32'(k), 32'(0));
        sc = cyc;
    endtask

    task automatic wait_rxv(output int rc);
        int k = 0;
        while (!bus.rx_valid && k < 300) begin step(1); k++; end
        if (!bus.rx_valid) chk("wait_rxv_bound", 32'(k), 32'(0));
        rc = cyc;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((bus.busy || bus.level != '0) && k < 2000) begin step(1); k++; end
        if (bus.busy) chk("wait_idle_bound", 32'(k), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    int p, s, r, sb, rb, n;
    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        bus.flush    = 1'b0;
        step(3);
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("rst_level",    32'(bus.level),    32'd0);
        rst = 1'b0;
        step(2);

        // Single byte: start latency 2, reply 21 cycles after start.
        rb = rxv_cyc.size();
        p  = cyc;
        push(8'h3C);
        wait_start(s);
        chk("t1_start_latency", 32'(s - p), 32'd2);
        chk("t1_tx",            32'(bus.m_tx_data), 32'h3C);
        wait_rxv(r);
        chk("t1_rx_latency",    32'(r - s), 32'd21);
        chk("t1_rx",            32'(bus.rx_data), 32'hA5);
        wait_idle();
        chk("t1_rx_count",      32'(rxv_cyc.size() - rb), 32'd1);
        chk("t1_level",         32'(bus.level), 32'd0);

        // Fill the FIFO behind an in-flight byte, overflow push dropped.
        sb = start_cyc.size();
        rb = rxv_cyc.size();
        push(8'h00);
        wait_start(s);
        for (int i = 1; i <= 8; i++) push(8'(i));
        chk("t2_full_ready", 32'(bus.wr_ready), 32'd0);
        chk("t2_full_level", 32'(bus.level),    32'd8);
        push(8'h09);
        chk("t2_drop_level", 32'(bus.level),    32'd8);
        wait_idle();
        chk("t2_starts", 32'(start_cyc.size() - sb), 32'd9);
        for (int i = 1; i <= 8 && sb + i < start_cyc.size(); i++) begin
            chk($sformatf("t2_order%0d", i), 32'(start_dat[sb + i]), 32'(i));
            chk($sformatf("t2_gap%0d", i), 32'(start_cyc[sb + i] - rxv_cyc[rb + i - 1]), 32'(GAP + 2));
        end

        // Spurious done while idle.
        rb = rxv_cyc.size();
        spur_cyc = cyc + 2;
        step(6);
        chk("t3_rx_data",  32'(bus.rx_data), 32'h91);
        chk("t3_rx_count", 32'(rxv_cyc.size() - rb), 32'd0);

        // Flush during the first WAIT_DONE.
        sb = start_cyc.size();
        rb = rxv_cyc.size();
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
        n = 0;
        while (start_cyc.size() == sb && n < 50) begin step(1); n++; end
        step(5);
        bus.flush = 1'b1;
        step(1);
        bus.flush = 1'b0;
        chk("t4_level", 32'(bus.level), 32'd0);
        wait_idle();
        step(60);
        chk("t4_starts",   32'(start_cyc.size() - sb), 32'd1);
        chk("t4_rx_count", 32'(rxv_cyc.size() - rb), 32'd1);
        chk("t4_rx",       32'(bus.rx_data), 32'h89);

        // Reset in WAIT_DONE, late done afterwards.
        rb = rxv_cyc.size();
        push(8'h55);
        wait_start(s);
        step(5);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(30);
        chk("t5_rx_count", 32'(rxv_cyc.size() - rb), 32'd0);
        chk("t5_rx",       32'(bus.rx_data),   32'h00);
        chk("t5_tx",       32'(bus.m_tx_data), 32'h00);
        chk("t5_busy",     32'(bus.busy),      32'd0);
        chk("t5_wr_ready", 32'(bus.wr_ready),  32'd1);

`ifdef SPI_SEQ_TIMEOUT_EN
        // Silent master: watchdog fires, next byte still launches.
        resp_en = 1'b0;
        push(8'h21);
        push(8'h22);
        wait_start(s);
        n = 0;
        while (!bus.timeout_err && n < 200) begin step(1); n++; end
        chk("t6_timeout_cyc", 32'(cyc - s), 32'(TMO));
        wait_start(s);
        chk("t6_next_tx", 32'(bus.m_tx_data), 32'h22);
        wait_idle();
`endif

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
